// File: rtl/eusci_baud_rate_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eusci_baud_rate_gen_pkg : shared eUSCI_A baud-rate definitions       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package eusci_baud_rate_gen_pkg;

   localparam int DEF_CNT_W       = 16;
   localparam int DEF_SAMPLE_TICK = 8;
   localparam int DEF_MIN_LF_PER  = 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/eusci_brclk_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eusci_brclk_prescaler : qualified up-counter with half/done strobes  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module eusci_brclk_prescaler #(
   parameter int LEN_W = 17
) (
   input  logic             MCLK,
   input  logic             reset,
   input  logic             clear,
   input  logic             BRCLK_en,
   input  logic [LEN_W-1:0] length,
   output logic             half,
   output logic             done
);

   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_nxt;
   logic [LEN_W-1:0] half_raw;
   logic [LEN_W-1:0] half_len;
   logic             advance;

   always_comb begin
      cnt_nxt  = cnt + {{(LEN_W-1){1'b0}}, 1'b1};
      half_raw = length >> 1;
      half_len = (half_raw == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : half_raw;
      advance  = BRCLK_en & ~clear;
      // Strobes fire on the tick that completes the count, so the caller can register them in the same edge
      done     = advance & (cnt_nxt == length);
      half     = advance & (cnt_nxt == half_len);
   end

   always_ff @(posedge MCLK or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear || done) begin
         cnt <= '0;
      end else if (advance) begin
         cnt <= cnt_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/eusci_baud_rate_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eusci_baud_rate_gen : modulated UART BITCLK generator (LF / OS16)     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module eusci_baud_rate_gen
   import eusci_baud_rate_gen_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SAMPLE_TICK = DEF_SAMPLE_TICK,
   parameter int MIN_LF_PER  = DEF_MIN_LF_PER
) (
   input  logic             MCLK,
   input  logic             reset,
   input  logic             BRCLK_en,
   input  logic             run,
   input  logic             restart,
   input  logic             wUCOS16,
   input  logic [CNT_W-1:0] wUCBRx,
   input  logic [3:0]       wUCBRFx,
   input  logic [7:0]       wUCBRSx,
   output logic             BITCLK,
   output logic             BITCLK16,
   output logic             oBitStart,
   output logic             oSample
);

   localparam int         LEN_W       = CNT_W + 1;
   localparam logic [3:0] SAMPLE_PREV = 4'(SAMPLE_TICK - 1);

   state_t           state;
   logic             os16_q;
   logic [CNT_W-1:0] brx_q;
   logic [3:0]       brf_q;
   logic [7:0]       brs_q;
   logic [2:0]       bit_idx;
   logic [3:0]       tick;

   logic             mod_bit;
   logic [LEN_W-1:0] lf_sum;
   logic [LEN_W-1:0] lf_len;
   logic [LEN_W-1:0] os_base;
   logic [LEN_W-1:0] os_len;
   logic [LEN_W-1:0] length;
   logic             clear;
   logic             half;
   logic             done;
   logic             start;
   logic             wrap;
   logic             tick_adv;

   always_comb begin
      mod_bit  = brs_q[3'd7 - bit_idx];
      lf_sum   = {1'b0, brx_q} + {{CNT_W{1'b0}}, mod_bit};
      lf_len   = (lf_sum < LEN_W'(MIN_LF_PER)) ? LEN_W'(MIN_LF_PER) : lf_sum;
      os_base  = (brx_q == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, brx_q};
      os_len   = os_base + {{CNT_W{1'b0}}, (tick < brf_q)}
                         + {{CNT_W{1'b0}}, ((tick == 4'd15) & mod_bit)};
      length   = os16_q ? os_len : lf_len;
      clear    = (state == ST_IDLE) | ~run | restart;
      // done is already suppressed by clear, so these imply RUN with no restart
      start    = run & ((state == ST_IDLE) | restart);
      wrap     = done & (~os16_q | (tick == 4'd15));
      tick_adv = done & os16_q & (tick != 4'd15);
   end

   eusci_brclk_prescaler #(
      .LEN_W (LEN_W)
   ) u_prescaler (
      .MCLK     (MCLK),
      .reset    (reset),
      .clear    (clear),
      .BRCLK_en (BRCLK_en),
      .length   (length),
      .half     (half),
      .done     (done)
   );

   // Configuration only moves at a bit boundary so a running bit keeps its length
   always_ff @(posedge MCLK or negedge reset) begin
      if (!reset) begin
         os16_q <= 1'b0;
         brx_q  <= '0;
         brf_q  <= '0;
         brs_q  <= '0;
      end else if (start || wrap) begin
         os16_q <= wUCOS16;
         brx_q  <= wUCBRx;
         brf_q  <= wUCBRFx;
         brs_q  <= wUCBRSx;
      end
   end

   always_ff @(posedge MCLK or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         bit_idx   <= '0;
         tick      <= '0;
         BITCLK    <= 1'b0;
         BITCLK16  <= 1'b0;
         oBitStart <= 1'b0;
         oSample   <= 1'b0;
      end else begin
         oBitStart <= 1'b0;
         oSample   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (run) begin
                  state     <= ST_RUN;
                  bit_idx   <= '0;
                  tick      <= '0;
                  BITCLK    <= 1'b0;
                  BITCLK16  <= wUCOS16;
                  oBitStart <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!run) begin
                  state    <= ST_IDLE;
                  bit_idx  <= '0;
                  tick     <= '0;
                  BITCLK   <= 1'b0;
                  BITCLK16 <= 1'b0;
               end else if (restart) begin
                  bit_idx   <= '0;
                  tick      <= '0;
                  BITCLK    <= 1'b0;
                  BITCLK16  <= wUCOS16;
                  oBitStart <= 1'b1;
               end else if (wrap) begin
                  bit_idx   <= bit_idx + 3'd1;
                  tick      <= '0;
                  BITCLK    <= 1'b0;
                  BITCLK16  <= wUCOS16;
                  oBitStart <= 1'b1;
               end else if (tick_adv) begin
                  tick     <= tick + 4'd1;
                  BITCLK16 <= 1'b1;
                  if (tick == SAMPLE_PREV) begin
                     BITCLK  <= 1'b1;
                     oSample <= 1'b1;
                  end
               end else if (half) begin
                  if (os16_q) begin
                     BITCLK16 <= 1'b0;
                  end else begin
                     BITCLK  <= 1'b1;
                     oSample <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_eusci_baud_rate_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_eusci_baud_rate_gen : directed self-checking bench                |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_eusci_baud_rate_gen;

   logic        MCLK;
   logic        reset;
   logic        BRCLK_en;
   logic        run;
   logic        restart;
   logic        wUCOS16;
   logic [15:0] wUCBRx;
   logic [3:0]  wUCBRFx;
   logic [7:0]  wUCBRSx;
   logic        BITCLK;
   logic        BITCLK16;
   logic        oBitStart;
   logic        oSample;

   int  tests_run    = 0;
   int  tests_failed = 0;
   int  overlaps     = 0;
   bit  toggle_en    = 1'b0;

   eusci_baud_rate_gen dut (
      .MCLK      (MCLK),
      .reset     (reset),
      .BRCLK_en  (BRCLK_en),
      .run       (run),
      .restart   (restart),
      .wUCOS16   (wUCOS16),
      .wUCBRx    (wUCBRx),
      .wUCBRFx   (wUCBRFx),
      .wUCBRSx   (wUCBRSx),
      .BITCLK    (BITCLK),
      .BITCLK16  (BITCLK16),
      .oBitStart (oBitStart),
      .oSample   (oSample)
   );

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   always @(negedge MCLK) begin
      if (oBitStart && oSample) overlaps++;
   end

   task automatic step();
      @(posedge MCLK);
      #1;
      if (toggle_en) BRCLK_en = ~BRCLK_en;
   endtask

   // Steps until the chosen pulse is seen; n = steps taken, or -1 on timeout
   task automatic wait_pulse(input bit want_sample, input int limit, output int n);
      int  i;
      bit  found;
      i     = 0;
      found = 1'b0;
      n     = -1;
      while (!found && i < limit) begin
         step();
         i++;
         if (want_sample ? oSample : oBitStart) begin
            found = 1'b1;
            n     = i;
         end
      end
   endtask

   task automatic configure(input bit os, input logic [15:0] brx,
                            input logic [3:0] brf, input logic [7:0] brs);
      wUCOS16 = os;
      wUCBRx  = brx;
      wUCBRFx = brf;
      wUCBRSx = brs;
   endtask

   task automatic go_idle();
      run = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      tests_run++;
      if ({BITCLK, BITCLK16, oBitStart, oSample} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %b want 0000", {BITCLK, BITCLK16, oBitStart, oSample});
      end
      reset = 1'b1;
      step();
      tests_run++;
      if (oBitStart !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release_no_pulse: got %b want 0", oBitStart);
      end
   endtask

   task automatic test_lf_basic();
      int n;
      configure(1'b0, 16'd4, 4'd0, 8'h00);
      run = 1'b1;
      step();
      tests_run++;
      if (oBitStart !== 1'b1) begin
         tests_failed++;
         $display("FAIL lf_first_start: got %b want 1", oBitStart);
      end
      for (int b = 0; b < 3; b++) begin
         wait_pulse(1'b1, 20, n);
         tests_run++;
         if (n !== 2 || BITCLK !== 1'b1) begin
            tests_failed++;
            $display("FAIL lf_sample_delay bit%0d: got %0d bitclk=%b want 2 bitclk=1", b, n, BITCLK);
         end
         wait_pulse(1'b0, 20, n);
         tests_run++;
         if (n !== 2 || BITCLK !== 1'b0 || BITCLK16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL lf_low_phase bit%0d: got %0d bitclk=%b bitclk16=%b want 2 0 0", b, n, BITCLK, BITCLK16);
         end
      end
      go_idle();
   endtask

   task automatic test_lf_modulation();
      int n;
      int exp_per [9] = '{5, 4, 4, 4, 4, 4, 4, 4, 5};
      configure(1'b0, 16'd4, 4'd0, 8'h80);
      run = 1'b1;
      step();
      for (int b = 0; b < 9; b++) begin
         wait_pulse(1'b0, 20, n);
         tests_run++;
         if (n !== exp_per[b]) begin
            tests_failed++;
            $display("FAIL lf_mod_period bit%0d: got %0d want %0d", b, n, exp_per[b]);
         end
      end
      go_idle();
   endtask

   task automatic test_os16();
      int n;
      configure(1'b1, 16'd2, 4'd3, 8'h00);
      run = 1'b1;
      step();
      tests_run++;
      if (oBitStart !== 1'b1 || BITCLK16 !== 1'b1) begin
         tests_failed++;
         $display("FAIL os16_start: got start=%b bitclk16=%b want 1 1", oBitStart, BITCLK16);
      end
      step();
      tests_run++;
      if (BITCLK16 !== 1'b0) begin
         tests_failed++;
         $display("FAIL os16_bitclk16_half: got %b want 0", BITCLK16);
      end
      wait_pulse(1'b1, 100, n);
      tests_run++;
      if (n !== 18 || BITCLK !== 1'b1) begin
         tests_failed++;
         $display("FAIL os16_sample_delay: got %0d bitclk=%b want 18 (19 from start) 1", n, BITCLK);
      end
      wait_pulse(1'b0, 100, n);
      tests_run++;
      if (n !== 16) begin
         tests_failed++;
         $display("FAIL os16_sample_to_start: got %0d want 16", n);
      end
      wait_pulse(1'b0, 100, n);
      tests_run++;
      if (n !== 35) begin
         tests_failed++;
         $display("FAIL os16_period: got %0d want 35", n);
      end
      go_idle();
      toggle_en = 1'b1;
      run = 1'b1;
      step();
      wait_pulse(1'b0, 200, n);
      wait_pulse(1'b1, 200, n);
      tests_run++;
      if (n !== 38) begin
         tests_failed++;
         $display("FAIL os16_gated_sample: got %0d want 38", n);
      end
      wait_pulse(1'b0, 200, n);
      tests_run++;
      if (n !== 32) begin
         tests_failed++;
         $display("FAIL os16_gated_tail: got %0d want 32", n);
      end
      wait_pulse(1'b0, 200, n);
      tests_run++;
      if (n !== 70) begin
         tests_failed++;
         $display("FAIL os16_gated_period: got %0d want 70", n);
      end
      toggle_en = 1'b0;
      BRCLK_en  = 1'b1;
      go_idle();
   endtask

   task automatic test_restart();
      int n;
      int pulses;
      configure(1'b1, 16'd2, 4'd3, 8'h00);
      run = 1'b1;
      step();
      repeat (10) step();
      restart = 1'b1;
      step();
      restart = 1'b0;
      tests_run++;
      if (oBitStart !== 1'b1 || BITCLK !== 1'b0) begin
         tests_failed++;
         $display("FAIL restart_early: got start=%b bitclk=%b want 1 0", oBitStart, BITCLK);
      end
      wait_pulse(1'b0, 100, n);
      tests_run++;
      if (n !== 35) begin
         tests_failed++;
         $display("FAIL restart_period: got %0d want 35", n);
      end
      repeat (25) step();
      restart = 1'b1;
      step();
      restart = 1'b0;
      tests_run++;
      if (oBitStart !== 1'b1 || BITCLK !== 1'b0) begin
         tests_failed++;
         $display("FAIL restart_high: got start=%b bitclk=%b want 1 0", oBitStart, BITCLK);
      end
      run = 1'b0;
      step();
      pulses = 0;
      restart = 1'b1;
      step();
      restart = 1'b0;
      if (oBitStart || oSample || BITCLK) pulses++;
      for (int i = 0; i < 40; i++) begin
         step();
         if (oBitStart || oSample || BITCLK || BITCLK16) pulses++;
      end
      tests_run++;
      if (pulses !== 0) begin
         tests_failed++;
         $display("FAIL idle_quiet: got %0d active cycles want 0", pulses);
      end
   endtask

   task automatic test_clamp();
      int n;
      configure(1'b0, 16'd0, 4'd0, 8'h00);
      run = 1'b1;
      step();
      for (int b = 0; b < 2; b++) begin
         wait_pulse(1'b0, 20, n);
         tests_run++;
         if (n !== 2) begin
            tests_failed++;
            $display("FAIL lf_clamp bit%0d: got %0d want 2", b, n);
         end
      end
      go_idle();
      configure(1'b1, 16'd0, 4'd0, 8'h00);
      run = 1'b1;
      step();
      wait_pulse(1'b0, 50, n);
      tests_run++;
      if (n !== 16) begin
         tests_failed++;
         $display("FAIL os16_clamp: got %0d want 16", n);
      end
      go_idle();
      configure(1'b0, 16'd4, 4'd0, 8'h00);
      run = 1'b1;
      step();
      step();
      wUCBRx = 16'd8;
      wait_pulse(1'b0, 20, n);
      tests_run++;
      if (n !== 3) begin
         tests_failed++;
         $display("FAIL midbit_change_current: got %0d want 3", n);
      end
      wait_pulse(1'b0, 20, n);
      tests_run++;
      if (n !== 8) begin
         tests_failed++;
         $display("FAIL midbit_change_next: got %0d want 8", n);
      end
      go_idle();
   endtask

   task automatic test_reset_mid();
      int n;
      configure(1'b0, 16'd4, 4'd0, 8'h00);
      run = 1'b1;
      step();
      wait_pulse(1'b1, 20, n);
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if ({BITCLK, BITCLK16, oBitStart, oSample} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL async_reset: got %b want 0000", {BITCLK, BITCLK16, oBitStart, oSample});
      end
      step();
      step();
      #2;
      reset = 1'b1;
      step();
      tests_run++;
      if (oBitStart !== 1'b1) begin
         tests_failed++;
         $display("FAIL start_after_reset: got %b want 1", oBitStart);
      end
      go_idle();
   endtask

   task automatic test_pulse_exclusive();
      tests_run++;
      if (overlaps !== 0) begin
         tests_failed++;
         $display("FAIL pulse_overlap: got %0d overlapping cycles want 0", overlaps);
      end
   endtask

   initial begin
      reset    = 1'b0;
      BRCLK_en = 1'b1;
      run      = 1'b0;
      restart  = 1'b0;
      configure(1'b0, 16'd0, 4'd0, 8'h00);
      step();
      step();
      test_reset();
      test_lf_basic();
      test_lf_modulation();
      test_os16();
      test_restart();
      test_clamp();
      test_reset_mid();
      test_pulse_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
